// File: rtl/key_voice_env.sv
// Two-voice key front end: synchronises the PS/2 key slots into sys_clk, maps scan
// codes to DDS phase increments and runs one ADSR envelope per voice on a shared tick.

module key_voice #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int ATTACK_STEP  = 8,
    parameter int DECAY_STEP   = 1,
    parameter int SUSTAIN_LVL  = 160,
    parameter int RELEASE_STEP = 2
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        key_on,
    input  logic [7:0]  key_code,
    output logic [31:0] phase_inc,
    output logic [7:0]  env,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } voice_state_t;

    // Frequencies are given in centi-Hz so the table stays exact in integer arithmetic.
    function automatic logic [31:0] inc_of(input longint unsigned centi_hz);
        longint unsigned den;
        longint unsigned q;
        den = longint'(CLK_HZ) * 100;
        q   = (centi_hz * 64'h1_0000_0000 + den / 2) / den;
        return q[31:0];
    endfunction

    localparam logic [31:0] INC_C4 = inc_of(26163);
    localparam logic [31:0] INC_D4 = inc_of(29366);
    localparam logic [31:0] INC_E4 = inc_of(32963);
    localparam logic [31:0] INC_F4 = inc_of(34923);
    localparam logic [31:0] INC_G4 = inc_of(39200);
    localparam logic [31:0] INC_A4 = inc_of(44000);
    localparam logic [31:0] INC_B4 = inc_of(49388);
    localparam logic [31:0] INC_C5 = inc_of(52325);
    localparam logic [31:0] INC_D5 = inc_of(58733);
    localparam logic [31:0] INC_E5 = inc_of(65926);
    localparam logic [31:0] INC_F5 = inc_of(69846);

    logic [2:0]   on_sync_q, on_sync_d;
    logic [7:0]   code_ff1_q, code_ff1_d;
    logic [7:0]   code_ff2_q, code_ff2_d;
    voice_state_t state_q, state_d;
    logic [7:0]   env_q, env_d;
    logic [31:0]  inc_q, inc_d;

    logic         rise, fall;
    logic         lut_hit;
    logic [31:0]  lut_inc;
    voice_state_t eff_state;
    logic [8:0]   attack_sum;
    logic [8:0]   decay_diff;
    logic [8:0]   release_diff;

    // Edges come from FF2 vs FF3 so a rise and a fall can never share a cycle.
    assign rise = on_sync_q[1] & ~on_sync_q[2];
    assign fall = ~on_sync_q[1] & on_sync_q[2];

    always_comb begin
        lut_hit = 1'b1;
        lut_inc = '0;
        case (code_ff2_q)
            8'h1C:   lut_inc = INC_C4;
            8'h1B:   lut_inc = INC_D4;
            8'h23:   lut_inc = INC_E4;
            8'h2B:   lut_inc = INC_F4;
            8'h34:   lut_inc = INC_G4;
            8'h33:   lut_inc = INC_A4;
            8'h3B:   lut_inc = INC_B4;
            8'h42:   lut_inc = INC_C5;
            8'h4B:   lut_inc = INC_D5;
            8'h4C:   lut_inc = INC_E5;
            8'h52:   lut_inc = INC_F5;
            default: lut_hit = 1'b0;
        endcase
    end

    assign attack_sum   = {1'b0, env_q} + 9'(ATTACK_STEP);
    assign decay_diff   = {1'b0, env_q} - 9'(DECAY_STEP);
    assign release_diff = {1'b0, env_q} - 9'(RELEASE_STEP);

    always_comb begin
        on_sync_d  = {on_sync_q[1:0], key_on};
        code_ff1_d = key_code;
        code_ff2_d = code_ff1_q;
        env_d      = env_q;
        inc_d      = inc_q;
        eff_state  = state_q;

        // Key edges resolve first; a coincident tick then applies the new state's rule.
        if (rise && lut_hit) begin
            eff_state = ATTACK;
            inc_d     = lut_inc;
        end else if (fall && state_q != IDLE) begin
            eff_state = RELEASE;
        end
        state_d = eff_state;

        if (tick) begin
            case (eff_state)
                IDLE: begin
                    env_d = 8'd0;
                    inc_d = 32'd0;
                end
                ATTACK: begin
                    if (attack_sum >= 9'd255) begin
                        env_d   = 8'd255;
                        state_d = DECAY;
                    end else begin
                        env_d = attack_sum[7:0];
                    end
                end
                DECAY: begin
                    // Borrow in bit 8 means we undershot; clamp to the sustain floor.
                    if (decay_diff[8] || decay_diff <= 9'(SUSTAIN_LVL)) begin
                        env_d   = 8'(SUSTAIN_LVL);
                        state_d = SUSTAIN;
                    end else begin
                        env_d = decay_diff[7:0];
                    end
                end
                SUSTAIN: env_d = env_q;
                RELEASE: begin
                    if (release_diff[8] || release_diff == 9'd0) begin
                        env_d   = 8'd0;
                        inc_d   = 32'd0;
                        state_d = IDLE;
                    end else begin
                        env_d = release_diff[7:0];
                    end
                end
                default: begin
                    env_d   = 8'd0;
                    inc_d   = 32'd0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            on_sync_q  <= '0;
            code_ff1_q <= '0;
            code_ff2_q <= '0;
            state_q    <= IDLE;
            env_q      <= '0;
            inc_q      <= '0;
        end else begin
            on_sync_q  <= on_sync_d;
            code_ff1_q <= code_ff1_d;
            code_ff2_q <= code_ff2_d;
            state_q    <= state_d;
            env_q      <= env_d;
            inc_q      <= inc_d;
        end
    end

    assign phase_inc = inc_q;
    assign env       = env_q;
    assign state_dbg = state_q;

endmodule

module key_voice_env #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int TICK_DIV     = 50_000,
    parameter int ATTACK_STEP  = 8,
    parameter int DECAY_STEP   = 1,
    parameter int SUSTAIN_LVL  = 160,
    parameter int RELEASE_STEP = 2
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        key1_on,
    input  logic [7:0]  key1_code,
    input  logic        key2_on,
    input  logic [7:0]  key2_code,
    output logic [31:0] v1_phase_inc,
    output logic [7:0]  v1_env,
    output logic        v1_active,
    output logic [31:0] v2_phase_inc,
    output logic [7:0]  v2_env,
    output logic        v2_active
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick;
    logic [2:0]    v1_state, v2_state;

    assign tick = (tick_cnt_q == CW'(TICK_DIV - 1));

    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) tick_cnt_q <= '0;
        else        tick_cnt_q <= tick_cnt_d;
    end

    key_voice #(
        .CLK_HZ(CLK_HZ), .ATTACK_STEP(ATTACK_STEP), .DECAY_STEP(DECAY_STEP),
        .SUSTAIN_LVL(SUSTAIN_LVL), .RELEASE_STEP(RELEASE_STEP)
    ) u_voice1 (
        .sys_clk(sys_clk), .reset(reset), .tick(tick),
        .key_on(key1_on), .key_code(key1_code),
        .phase_inc(v1_phase_inc), .env(v1_env), .state_dbg(v1_state)
    );

    key_voice #(
        .CLK_HZ(CLK_HZ), .ATTACK_STEP(ATTACK_STEP), .DECAY_STEP(DECAY_STEP),
        .SUSTAIN_LVL(SUSTAIN_LVL), .RELEASE_STEP(RELEASE_STEP)
    ) u_voice2 (
        .sys_clk(sys_clk), .reset(reset), .tick(tick),
        .key_on(key2_on), .key_code(key2_code),
        .phase_inc(v2_phase_inc), .env(v2_env), .state_dbg(v2_state)
    );

    // IDLE is encoded as zero in the voice state.
    assign v1_active = (v1_state != 3'd0);
    assign v2_active = (v2_state != 3'd0);

endmodule
